input_mem: RTL and testbench

INPUT_MEM -- requirements
Module: input_mem

---
 rtl/input_mem_pkg.sv | 19 +
 rtl/imem_array.sv | 102 ++++++++++
 rtl/input_mem.sv | 88 ++++++++
 tb/tb_input_mem.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/input_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : input_mem_pkg
// Purpose : Shared sizes and FSM encoding for the input pixel memory.
// Revision: 1.0
// ============================================================================
package input_mem_pkg;

    localparam int IMEM_BYTES  = 64;
    localparam int IMEM_ADDR_W = 6;
    localparam int IMEM_CNT_W  = 5;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } imem_state_t;

endpackage : input_mem_pkg
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
// Module  : imem_array
// Purpose : 64x8 pixel store with word write port and three byte read ports.
// Revision: 1.0
// ============================================================================
module imem_array #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-3:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic              rd_en_i,
    input  logic [7:0]        raddr_b_i,
    input  logic [7:0]        raddr_g_i,
    input  logic [7:0]        raddr_r_i,
    output logic [7:0]        pix_b_o,
    output logic [7:0]        pix_g_o,
    output logic [7:0]        pix_r_o,
    output logic              pix_valid_o
);

    logic [7:0] mem_q [MEM_BYTES];
    logic [7:0] pix_b_q, pix_g_q, pix_r_q;
    logic       pix_valid_q;

    logic [ADDR_W-1:0] ab_w, ag_w, ar_w;
    logic [7:0]        pix_b_d, pix_g_d, pix_r_d;

    // Upper address bits are discarded so reads wrap modulo the capacity.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [7:0] a);
        return ADDR_W'(a % 8'(MEM_BYTES));
    endfunction

    function automatic logic [7:0] rd_byte(
        input logic [ADDR_W-1:0] a,
        input logic [7:0]        cur,
        input logic              we,
        input logic [ADDR_W-3:0] wa,
        input logic [31:0]       wd
    );
        logic [7:0] b;
        b = cur;
        if (we && (a[ADDR_W-1:2] == wa)) begin
            case (a[1:0])
                2'd0:    b = wd[31:24];
                2'd1:    b = wd[23:16];
                2'd2:    b = wd[15:8];
                default: b = wd[7:0];
            endcase
        end
        return b;
    endfunction

    always_comb begin
        ab_w    = wrap_addr(raddr_b_i);
        ag_w    = wrap_addr(raddr_g_i);
        ar_w    = wrap_addr(raddr_r_i);
        pix_b_d = rd_byte(ab_w, mem_q[ab_w], we_i, waddr_i, wdata_i);
        pix_g_d = rd_byte(ag_w, mem_q[ag_w], we_i, waddr_i, wdata_i);
        pix_r_d = rd_byte(ar_w, mem_q[ar_w], we_i, waddr_i, wdata_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[ADDR_W'(i)] <= 8'h00;
            end
        end else if (we_i) begin
            // Byte offset 0 is the most significant byte of the bus word.
            for (int i = 0; i < 4; i++) begin
                mem_q[{waddr_i, i[1:0]}] <= wdata_i[8*(3-i) +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_b_q     <= 8'h00;
            pix_g_q     <= 8'h00;
            pix_r_q     <= 8'h00;
            pix_valid_q <= 1'b0;
        end else begin
            pix_valid_q <= rd_en_i;
            if (rd_en_i) begin
                pix_b_q <= pix_b_d;
                pix_g_q <= pix_g_d;
                pix_r_q <= pix_r_d;
            end
        end
    end

    assign pix_b_o     = pix_b_q;
    assign pix_g_o     = pix_g_q;
    assign pix_r_o     = pix_r_q;
    assign pix_valid_o = pix_valid_q;

endmodule : imem_array
`default_nettype wire

// File: rtl/input_mem.sv
`default_nettype none
// ============================================================================
// Module  : input_mem
// Purpose : Fills a 16-word pixel buffer from a ready/valid bus and serves
//           three registered byte reads per cycle.
// Revision: 1.0
// ============================================================================
module input_mem
    import input_mem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int ADDR_W    = IMEM_ADDR_W
) (
    input  logic                  I_IMEM_HCLK,
    input  logic                  I_IMEM_HRESET,
    input  logic [31:0]           I_IMEM_RDATA,
    input  logic                  I_IMEM_RDATA_VALID,
    output logic                  O_IMEM_RDATA_READY,
    input  logic                  I_IMEM_CLEAR,
    input  logic                  I_IMEM_RD_EN,
    input  logic [7:0]            I_IMEM_PIXEL_ADDRB,
    input  logic [7:0]            I_IMEM_PIXEL_ADDRG,
    input  logic [7:0]            I_IMEM_PIXEL_ADDRR,
    output logic [7:0]            O_IMEM_PIXEL_B,
    output logic [7:0]            O_IMEM_PIXEL_G,
    output logic [7:0]            O_IMEM_PIXEL_R,
    output logic                  O_IMEM_PIXEL_VALID,
    output logic                  O_IMEM_FULL,
    output logic [IMEM_CNT_W-1:0] O_IMEM_WORD_COUNT
);

    localparam int WORDS = MEM_BYTES / 4;

    imem_state_t           state_q, state_d;
    logic [IMEM_CNT_W-1:0] count_q, count_d;
    logic                  xfer_w;

    always_ff @(posedge I_IMEM_HCLK or posedge I_IMEM_HRESET) begin
        if (I_IMEM_HRESET) begin
            state_q <= ST_FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Clear has priority over a coincident transfer, which is then dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        xfer_w  = I_IMEM_RDATA_VALID && (state_q == ST_FILL) && !I_IMEM_CLEAR;
        if (I_IMEM_CLEAR) begin
            state_d = ST_FILL;
            count_d = '0;
        end else if (xfer_w) begin
            count_d = count_q + IMEM_CNT_W'(1);
            if (count_q == IMEM_CNT_W'(WORDS - 1)) begin
                state_d = ST_FULL;
            end
        end
    end

    assign O_IMEM_RDATA_READY = (state_q == ST_FILL);
    assign O_IMEM_FULL        = (state_q == ST_FULL);
    assign O_IMEM_WORD_COUNT  = count_q;

    imem_array #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_array (
        .clk_i       (I_IMEM_HCLK),
        .rst_i       (I_IMEM_HRESET),
        .we_i        (xfer_w),
        .waddr_i     (count_q[ADDR_W-3:0]),
        .wdata_i     (I_IMEM_RDATA),
        .rd_en_i     (I_IMEM_RD_EN),
        .raddr_b_i   (I_IMEM_PIXEL_ADDRB),
        .raddr_g_i   (I_IMEM_PIXEL_ADDRG),
        .raddr_r_i   (I_IMEM_PIXEL_ADDRR),
        .pix_b_o     (O_IMEM_PIXEL_B),
        .pix_g_o     (O_IMEM_PIXEL_G),
        .pix_r_o     (O_IMEM_PIXEL_R),
        .pix_valid_o (O_IMEM_PIXEL_VALID)
    );

endmodule : input_mem
`default_nettype wire

// File: tb/tb_input_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_mem
// Purpose : Self-checking bench for input_mem against a byte-array model.
// Revision: 1.0
// ============================================================================
module tb_input_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wdata;
    logic        valid, clr, rd_en;
    logic [7:0]  ab, ag, ar;
    logic        ready, full, pv;
    logic [7:0]  pb, pg, pr;
    logic [4:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    input_mem dut (
        .I_IMEM_HCLK        (clk),
        .I_IMEM_HRESET      (rst),
        .I_IMEM_RDATA       (wdata),
        .I_IMEM_RDATA_VALID (valid),
        .O_IMEM_RDATA_READY (ready),
        .I_IMEM_CLEAR       (clr),
        .I_IMEM_RD_EN       (rd_en),
        .I_IMEM_PIXEL_ADDRB (ab),
        .I_IMEM_PIXEL_ADDRG (ag),
        .I_IMEM_PIXEL_ADDRR (ar),
        .O_IMEM_PIXEL_B     (pb),
        .O_IMEM_PIXEL_G     (pg),
        .O_IMEM_PIXEL_R     (pr),
        .O_IMEM_PIXEL_VALID (pv),
        .O_IMEM_FULL        (full),
        .O_IMEM_WORD_COUNT  (count)
    );

    // Model: a plain byte array, a word counter and a full flag.
    logic [7:0] m_mem [64];
    int         m_count;
    bit         m_full;
    logic [7:0] m_b, m_g, m_r;
    bit         m_pv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
            m_count = 0;
            m_full  = 1'b0;
            m_b = 8'h00; m_g = 8'h00; m_r = 8'h00;
            m_pv = 1'b0;
        end else begin
            if (clr) begin
                m_count = 0;
                m_full  = 1'b0;
            end else if (valid && !m_full) begin
                for (int i = 0; i < 4; i++) m_mem[4*m_count + i] = wdata[31-8*i -: 8];
                m_count = m_count + 1;
                m_full  = (m_count == 16);
            end
            if (rd_en) begin
                m_b = m_mem[ab % 64];
                m_g = m_mem[ag % 64];
                m_r = m_mem[ar % 64];
                m_pv = 1'b1;
            end else begin
                m_pv = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_count", 32'(count), 32'(m_count));
            check("model_full",  32'(full),  32'(m_full));
            check("model_ready", 32'(ready), 32'(!m_full));
            check("model_pv",    32'(pv),    32'(m_pv));
            check("model_b",     32'(pb),    32'(m_b));
            check("model_g",     32'(pg),    32'(m_g));
            check("model_r",     32'(pr),    32'(m_r));
        end
    end

    task automatic step(input bit v, input logic [31:0] d, input bit c, input bit r,
                        input logic [7:0] b, input logic [7:0] g, input logic [7:0] rr);
        valid = v; wdata = d; clr = c; rd_en = r;
        ab = b; ag = g; ar = rr;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] base;
        rst = 1'b1; valid = 1'b0; wdata = '0; clr = 1'b0; rd_en = 1'b0;
        ab = '0; ag = '0; ar = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        check("reset_count", 32'(count), 0);
        check("reset_full",  32'(full),  0);
        check("reset_ready", 32'(ready), 1);
        check("reset_pv",    32'(pv),    0);
        check("reset_pix_b", 32'(pb),    0);

        // Fill: word k = {4k, 4k+1, 4k+2, 4k+3}; the 17th word must be ignored.
        for (int k = 0; k < 17; k++) begin
            base = 8'(4 * k);
            step(1'b1, {base, base + 8'd1, base + 8'd2, base + 8'd3}, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
            if (k == 15) begin
                check("fill_count16", 32'(count), 16);
                check("fill_full",    32'(full),  1);
                check("fill_ready0",  32'(ready), 0);
            end
        end
        check("overflow_count", 32'(count), 16);

        step(1'b0, 32'h0, 1'b0, 1'b1, 8'h05, 8'h2A, 8'h3F);
        check("read_b", 32'(pb), 32'h05);
        check("read_g", 32'(pg), 32'h2A);
        check("read_r", 32'(pr), 32'h3F);
        check("read_pv", 32'(pv), 1);

        step(1'b0, 32'h0, 1'b0, 1'b1, 8'h45, 8'h05, 8'h05);
        check("wrap_b", 32'(pb), 32'h05);
        check("alias_g", 32'(pg), 32'h05);
        check("alias_r", 32'(pr), 32'h05);

        step(1'b0, 32'h0, 1'b0, 1'b0, 8'h3F, 8'h3F, 8'h3F);
        check("hold_pv0", 32'(pv), 0);
        check("hold_b",   32'(pb), 32'h05);

        step(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
        check("clear_count", 32'(count), 0);
        check("clear_ready", 32'(ready), 1);

        step(1'b1, 32'hA0A1A2A3, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        step(1'b1, 32'hB0B1B2B3, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 8'h00, 8'h09, 8'h0B);
        check("bypass_g", 32'(pg), 32'hAD);
        check("bypass_r", 32'(pr), 32'hEF);
        check("prev_fill_b", 32'(pb), 32'hA0);

        for (int k = 0; k < 4; k++) begin
            base = 8'hC0 + 8'(4 * k);
            step(1'b1, {base, base + 8'd1, base + 8'd2, base + 8'd3}, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        end
        check("count7", 32'(count), 7);

        step(1'b1, 32'h11223344, 1'b1, 1'b0, 8'h0, 8'h0, 8'h0);
        check("clear_wins_count", 32'(count), 0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 8'h1C, 8'h08, 8'h18);
        check("dropped_word", 32'(pb), 32'h1C);
        check("kept_g",       32'(pg), 32'hDE);
        check("kept_r",       32'(pr), 32'hCC);

        step(1'b1, 32'h55667788, 1'b0, 1'b1, 8'h01, 8'h43, 8'h1C);
        check("bypass2_b", 32'(pb), 32'h66);
        check("bypass2_g", 32'(pg), 32'h88);
        step(1'b1, 32'h99AABBCC, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        step(1'b1, 32'hDDEEFF00, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);

        // Asynchronous reset between edges must clear outputs without a clock.
        #2 rst = 1'b1;
        #1;
        check("areset_count", 32'(count), 0);
        check("areset_b",     32'(pb),    0);
        check("areset_g",     32'(pg),    0);
        check("areset_ready", 32'(ready), 1);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1, 8'h00, 8'h01, 8'h08);
        check("post_reset_b", 32'(pb), 0);
        check("post_reset_g", 32'(pg), 0);
        check("post_reset_pv", 32'(pv), 1);

        step(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_input_mem
`default_nettype wire
